// File: rtl/execute_mem_lsu_pkg.sv
// Shared instruction definitions and LSU state encoding.
//   LEN_OPECODE / OPECODE_LD / OPECODE_ST : opcode field width and decodes
//   lsu_state_e                           : IDLE, RD (read in flight), FULL (result held)
package execute_mem_lsu_pkg;

  localparam int unsigned LEN_OPECODE = 7;

  localparam logic [LEN_OPECODE-1:0] OPECODE_LD = 7'b000_0011;
  localparam logic [LEN_OPECODE-1:0] OPECODE_ST = 7'b010_0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    FULL = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/execute_mem_lsu_mem_sp.sv
// Single-port synchronous RAM; Q is registered one edge after A, and a
// read during a write returns the old word.
//   clk : clock
//   A   : word address
//   W   : write enable
//   D   : write data
//   Q   : registered read data
module mem_sp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] A,
  input  logic              W,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array and read register; no reset, contents survive rst_n.
  always_ff @(posedge clk) begin
    if (W) mem_q[A] <= D;
    Q <= mem_q[A];
  end

endmodule

// File: rtl/execute_mem_lsu.sv
// Load/store unit of the execute-memory stage.
// Loads return on a valid/ready output after two edges; stores complete on
// the accepting edge and produce no output.
// Optional macro EXECUTE_MEM_LSU_ERR_EN: flag out-of-range addresses (writes
// suppressed, loads return 0 with out_err=1). Undefined: address truncated.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake
//   opecode             : OPECODE_LD, OPECODE_ST, anything else is a no-op
//   data_rd             : store base address
//   data_rs             : load base address / store data
//   imm_ex              : signed address offset
//   out_valid/out_ready : load result handshake
//   data_o, out_err     : load data and fault flag
module execute_mem_lsu
  import execute_mem_lsu_pkg::*;
#(
  parameter int unsigned LEN_REG    = 32,
  parameter int unsigned MEM_ADDR   = 16,
  parameter int unsigned LEN_IMM_EX = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LEN_OPECODE-1:0] opecode,
  input  logic [LEN_REG-1:0]     data_rd,
  input  logic [LEN_REG-1:0]     data_rs,
  input  logic [LEN_IMM_EX-1:0]  imm_ex,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEN_REG-1:0]     data_o,
  output logic                   out_err
);

  lsu_state_e         state_q, state_d;
  logic [LEN_REG-1:0] data_q, data_d;
  logic               err_q, err_d;
  logic               ld_err_q, ld_err_d;

  logic               accept, is_ld, is_st, fault, mem_we;
  logic [LEN_REG-1:0] base, imm_sx, ea, mem_q;

  // Request decode and effective address.
  assign in_ready = (state_q == IDLE) || ((state_q == FULL) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_ld    = (opecode == OPECODE_LD);
  assign is_st    = (opecode == OPECODE_ST);
  assign base     = is_ld ? data_rs : data_rd;
  assign imm_sx   = LEN_REG'($signed(imm_ex));
  assign ea       = base + imm_sx;

`ifdef EXECUTE_MEM_LSU_ERR_EN
  // Negative or beyond the RAM depth: all bits above the word index must be 0.
  assign fault = |ea[LEN_REG-1:MEM_ADDR];
`else
  logic unused_ea_hi;
  assign unused_ea_hi = |ea[LEN_REG-1:MEM_ADDR];
  assign fault        = 1'b0;
`endif

  // rst_n gating keeps stores out of the RAM while reset holds in_ready high.
  assign mem_we = accept && is_st && !fault && rst_n;

  mem_sp #(
    .DATA_W (LEN_REG),
    .ADDR_W (MEM_ADDR)
  ) u_mem (
    .clk (clk),
    .A   (ea[MEM_ADDR-1:0]),
    .W   (mem_we),
    .D   (data_rs),
    .Q   (mem_q)
  );

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      err_q    <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      err_q    <= err_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Next state; a faulting load still travels through RD so latency is fixed.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    err_d    = err_q;
    ld_err_d = ld_err_q;
    case (state_q)
      IDLE, FULL: begin
        if (accept) begin
          if (is_ld) begin
            ld_err_d = fault;
            state_d  = RD;
          end else begin
            state_d  = IDLE;
          end
        end else if ((state_q == FULL) && out_ready) begin
          state_d = IDLE;
        end
      end
      RD: begin
        state_d = FULL;
        data_d  = ld_err_q ? '0 : mem_q;
        err_d   = ld_err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == FULL);
  assign data_o    = data_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_execute_mem_lsu.sv
// Randomized and directed bench for execute_mem_lsu with a transaction-level
// reference: a word-indexed memory map plus a queue of outstanding load results.
module tb_execute_mem_lsu;
  import execute_mem_lsu_pkg::*;

  localparam logic [LEN_OPECODE-1:0] OP_NOP = 7'b001_0011;
`ifdef EXECUTE_MEM_LSU_ERR_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [LEN_OPECODE-1:0] opecode;
  logic [31:0]            data_rd, data_rs, imm_ex;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            data_o;
  logic                   out_err;

  execute_mem_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opecode   (opecode),
    .data_rd   (data_rd),
    .data_rs   (data_rs),
    .imm_ex    (imm_ex),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          rdy;
  } res_t;

  res_t        res_q[$];
  logic [31:0] mem_m[int];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_fault(input logic [31:0] ea);
    return FAULT_EN && (ea >= 32'h0001_0000);
  endfunction

  // One clock: drive at negedge, compare, then advance the model past the posedge.
  task automatic step(input logic v, input logic [LEN_OPECODE-1:0] op,
                      input logic [31:0] rd, input logic [31:0] rs,
                      input logic [31:0] imm, input logic ordy);
    logic        exp_ov, exp_ir, flt;
    logic [31:0] ea;
    int          idx;
    res_t        r;
    @(negedge clk);
    in_valid = v; opecode = op; data_rd = rd; data_rs = rs; imm_ex = imm; out_ready = ordy;
    #1;
    exp_ov = (res_q.size() > 0) && (res_q[0].rdy <= cyc);
    exp_ir = (res_q.size() == 0) || (exp_ov && ordy);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    if (exp_ov) begin
      check("data_o", data_o, res_q[0].data);
      check("out_err", 32'(out_err), 32'(res_q[0].err));
    end
    if (!FAULT_EN) check("out_err_tied", 32'(out_err), 32'd0);
    if (exp_ov && ordy) void'(res_q.pop_front());
    if (v && exp_ir) begin
      ea  = ((op == OPECODE_LD) ? rs : rd) + imm;
      flt = is_fault(ea);
      idx = int'(ea & 32'h0000_FFFF);
      if (op == OPECODE_ST && !flt) begin
        mem_m[idx] = rs;
      end else if (op == OPECODE_LD) begin
        r.data = flt ? 32'd0 : (mem_m.exists(idx) ? mem_m[idx] : 32'd0);
        r.err  = flt;
        r.rdy  = cyc + 2;
        res_q.push_back(r);
      end
    end
    cyc++;
  endtask

  // Reset for a few cycles while a store to word 3 is offered; it must not land.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; opecode = OPECODE_ST; data_rd = 32'd3; data_rs = 32'hBAD0_BAD0;
    imm_ex = 32'd0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_o", data_o, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    res_q.delete();
  endtask

  task automatic ld(input int t, input logic ordy);
    step(1'b1, OPECODE_LD, $urandom, 32'(t), 32'd0, ordy);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, OP_NOP, 32'd0, 32'd0, 32'd0, ordy);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] held, imm, base;
    int          t, sel, n_ov;
    in_valid = 1'b0; opecode = OP_NOP; data_rd = '0; data_rs = '0; imm_ex = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    do_reset(3);

    // Fill words 0..63 so every later load has a known value.
    for (int i = 0; i < 64; i++) step(1'b1, OPECODE_ST, 32'(i), $urandom, 32'd0, 1'b1);

    // Store then load back through base+offset.
    step(1'b1, OPECODE_ST, 32'h10, 32'hDEAD_BEEF, 32'd4, 1'b1);
    step(1'b1, OPECODE_LD, 32'h0, 32'h10, 32'd4, 1'b1);
    idle(1'b0);
    check("ld_rd_no_valid", 32'(out_valid), 32'd0);
    idle(1'b0);
    check("st_ld_valid", 32'(out_valid), 32'd1);
    check("st_ld_data", data_o, 32'hDEAD_BEEF);
    idle(1'b1);

    // Backpressure: result held while out_ready is low, then same-edge reload.
    ld(7, 1'b1);
    held = mem_m[7];
    idle(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, OPECODE_LD, 32'd0, 32'd9, 32'd0, 1'b0);
      check("hold_data", data_o, held);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    step(1'b1, OPECODE_LD, 32'd0, 32'd9, 32'd0, 1'b1);
    check("reload_in_ready", 32'(in_ready), 32'd1);
    idle(1'b1);
    check("reload_rd_valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back loads: one result every two cycles.
    n_ov = 0;
    for (int i = 0; i < 10; i++) begin
      ld(i + 20, 1'b1);
      n_ov += int'(out_valid);
    end
    check("b2b_results", 32'(n_ov), 32'd4);
    idle(1'b1);
    idle(1'b1);

`ifdef EXECUTE_MEM_LSU_ERR_EN
    step(1'b1, OPECODE_LD, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    idle(1'b0);
    idle(1'b0);
    check("flt_ld_data", data_o, 32'd0);
    check("flt_ld_err", 32'(out_err), 32'd1);
    idle(1'b1);
    held = mem_m[0];
    step(1'b1, OPECODE_ST, 32'h0001_0000, 32'h1234_5678, 32'd0, 1'b1);
    ld(0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    check("flt_st_kept", data_o, held);
    idle(1'b1);
`else
    step(1'b1, OPECODE_ST, 32'h0001_0000, 32'hCAFE_F00D, 32'd5, 1'b1);
    ld(5, 1'b1);
    idle(1'b0);
    idle(1'b0);
    check("trunc_st_data", data_o, 32'hCAFE_F00D);
    check("trunc_err", 32'(out_err), 32'd0);
    idle(1'b1);
`endif

    // Reset during RD: result discarded, RAM contents kept.
    ld(11, 1'b1);
    do_reset(2);
    idle(1'b0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    ld(3, 1'b1);
    idle(1'b0);
    idle(1'b0);
    check("post_rst_ram", data_o, mem_m[3]);
    idle(1'b1);

    // Random traffic confined to words 0..63 via signed offsets.
    for (int i = 0; i < 400; i++) begin
      t    = int'($urandom_range(63, 0));
      imm  = 32'($urandom_range(31, 0)) - 32'd16;
      base = 32'(t) - imm;
      sel  = int'($urandom_range(7, 0));
      if (sel < 4)
        step($urandom_range(3, 0) != 0, OPECODE_LD, $urandom, base, imm, $urandom_range(2, 0) != 0);
      else if (sel < 7)
        step($urandom_range(3, 0) != 0, OPECODE_ST, base, $urandom, imm, $urandom_range(2, 0) != 0);
      else
        step(1'b1, OP_NOP, base, $urandom, imm, $urandom_range(2, 0) != 0);
    end
    repeat (4) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
